spectro_frame_receiver: RTL and testbench

//  Host-side receiver for the spectrogram extractor serial readout. Deserializes one readout frame:
//  32-bit event timestamp on lane 0, then a stream of 3-bit energy codes for ch1 (lane 0) and ch2 (lane 1).

---
 rtl/spectro_pkg.sv | 33 +++
 rtl/spectro_shift_capture.sv | 44 ++++
 rtl/spectro_frame_receiver.sv | 193 +++++++++++++++++++
 tb/tb_spectro_frame_receiver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectro_pkg.sv
// Shared constants, timestamp field layout and receiver state encoding for
// the spectrogram readout receiver.
package spectro_pkg;

  localparam int TIME_BITS     = 32;
  localparam int CODE_BITS     = 3;
  localparam int MAX_SAMPLES   = 512;
  localparam int IDX_BITS      = $clog2(MAX_SAMPLES);
  localparam int CNT_BITS      = IDX_BITS + 1;
  localparam int TIME_CNT_BITS = $clog2(TIME_BITS + 1);
  localparam int CODE_CNT_BITS = $clog2(CODE_BITS + 1);

  // Timestamp field layout: day[31:27] hour[26:22] min[21:16] sec[15:10] ms[9:0]
  localparam int TS_MS_LSB   = 0;
  localparam int TS_MS_W     = 10;
  localparam int TS_SEC_LSB  = 10;
  localparam int TS_SEC_W    = 6;
  localparam int TS_MIN_LSB  = 16;
  localparam int TS_MIN_W    = 6;
  localparam int TS_HOUR_LSB = 22;
  localparam int TS_HOUR_W   = 5;
  localparam int TS_DAY_LSB  = 27;
  localparam int TS_DAY_W    = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_T,
    T_SHIFT,
    WAIT_CH,
    C_SHIFT
  } rx_state_t;

endpackage

// File: rtl/spectro_shift_capture.sv
// Serial-in word capture: shifts one bit per enabled cycle until WIDTH bits
// are held, then ignores further bits until cleared.
module spectro_shift_capture #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         enable,
  input  logic                         bit_in,
  output logic [WIDTH-1:0]             word,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic                         full
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shifted;

  // First received bit ends up in the MSB or the LSB depending on bit order
  if (MSB_FIRST) begin : g_msb_first
    assign shifted = {word[WIDTH-2:0], bit_in};
  end else begin : g_lsb_first
    assign shifted = {bit_in, word[WIDTH-1:1]};
  end

  assign full = (count == CNT_W'(WIDTH));

  // Word and bit counter; clear restarts the word, full word holds
  always_ff @(posedge clk) begin
    if (!reset) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (enable && !full) begin
      word  <= shifted;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spectro_frame_receiver.sv
// Deserializes one spectrogram readout frame: a timestamp on lane 0 followed
// by ch1/ch2 energy code pairs, with frame summary and protocol checking.
module spectro_frame_receiver
  import spectro_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           serial_in,
  input  logic                 sl_ch,
  input  logic                 sl_time,
  input  logic                 serial_readout,
  input  logic                 sending_data,
  output logic [TIME_BITS-1:0] event_time,
  output logic                 time_valid,
  output logic [CODE_BITS-1:0] sample_ch1,
  output logic [CODE_BITS-1:0] sample_ch2,
  output logic [IDX_BITS-1:0]  sample_idx,
  output logic                 sample_valid,
  output logic                 frame_done,
  output logic [CNT_BITS-1:0]  sample_count,
  output logic                 overflow,
  output logic                 frame_error,
  output logic                 busy
);

  rx_state_t state_reg;
  logic      sd_prev_reg;
  logic [CNT_BITS-1:0] accepted_reg;
  logic      ovf_reg;
  logic      time_pend_reg;
  logic      samp_pend_reg;
  logic [IDX_BITS-1:0] pend_idx_reg;

  logic [TIME_BITS-1:0]     time_word;
  logic [TIME_CNT_BITS-1:0] time_cnt;
  logic                     time_full;
  logic [CODE_BITS-1:0]     code_word [2];
  logic [CODE_CNT_BITS-1:0] code_cnt [2];
  logic [1:0]               code_full;

  logic sd_rise, sd_fall;
  logic in_time_phase, in_code_phase;
  logic time_clear, time_shift, time_last;
  logic code_clear, code_shift, code_last;
  logic frame_abort;
  logic unused_bits;

  // sd_prev_reg resets high so a level already high out of reset is not a rise
  assign sd_rise = sending_data & ~sd_prev_reg;
  assign sd_fall = ~sending_data & sd_prev_reg;

  assign in_time_phase = (state_reg == WAIT_T) || (state_reg == T_SHIFT);
  assign in_code_phase = (state_reg == WAIT_CH) || (state_reg == C_SHIFT);

  // A strobe cycle is a load cycle: it never also takes a bit
  assign time_clear = ((state_reg == IDLE) && sd_rise) ||
                      (in_time_phase && sl_time && !sl_ch && !sd_fall);
  assign time_shift = (state_reg == T_SHIFT) && serial_readout &&
                      !sd_fall && !sl_ch && !sl_time;
  assign time_last  = time_shift && (time_cnt == TIME_CNT_BITS'(TIME_BITS - 1));

  assign code_clear = ((state_reg == IDLE) && sd_rise) ||
                      (in_code_phase && sl_ch && !sl_time && !sd_fall);
  assign code_shift = (state_reg == C_SHIFT) && serial_readout &&
                      !sd_fall && !sl_ch && !sl_time;
  assign code_last  = code_shift && (code_cnt[0] == CODE_CNT_BITS'(CODE_BITS - 1));

  // Closing in WAIT_CH is a normal end of frame; every other violation aborts
  assign frame_abort = (in_time_phase && (sd_fall || sl_ch)) ||
                       ((state_reg == WAIT_CH) && !sd_fall && sl_time) ||
                       ((state_reg == C_SHIFT) && (sd_fall || sl_time));

  assign busy = (state_reg != IDLE);

  assign unused_bits = ^{time_full, code_full, code_cnt[1]};

  spectro_shift_capture #(.WIDTH(TIME_BITS), .MSB_FIRST(MSB_FIRST)) u_time (
    .clk    (clk),
    .reset  (reset),
    .clear  (time_clear),
    .enable (time_shift),
    .bit_in (serial_in[0]),
    .word   (time_word),
    .count  (time_cnt),
    .full   (time_full)
  );

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_code
    spectro_shift_capture #(.WIDTH(CODE_BITS), .MSB_FIRST(MSB_FIRST)) u_code (
      .clk    (clk),
      .reset  (reset),
      .clear  (code_clear),
      .enable (code_shift),
      .bit_in (serial_in[gi]),
      .word   (code_word[gi]),
      .count  (code_cnt[gi]),
      .full   (code_full[gi])
    );
  end

  // Frame FSM, sample accounting and registered outputs (one cycle after the last bit)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      sd_prev_reg   <= 1'b1;
      accepted_reg  <= '0;
      ovf_reg       <= 1'b0;
      time_pend_reg <= 1'b0;
      samp_pend_reg <= 1'b0;
      pend_idx_reg  <= '0;
      event_time    <= '0;
      time_valid    <= 1'b0;
      sample_ch1    <= '0;
      sample_ch2    <= '0;
      sample_idx    <= '0;
      sample_valid  <= 1'b0;
      frame_done    <= 1'b0;
      sample_count  <= '0;
      overflow      <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      sd_prev_reg   <= sending_data;
      time_valid    <= 1'b0;
      sample_valid  <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      time_pend_reg <= 1'b0;
      samp_pend_reg <= 1'b0;

      if (time_pend_reg) begin
        event_time <= time_word;
        time_valid <= 1'b1;
      end
      if (samp_pend_reg) begin
        sample_ch1   <= code_word[0];
        sample_ch2   <= code_word[1];
        sample_idx   <= pend_idx_reg;
        sample_valid <= 1'b1;
      end

      if (frame_abort) begin
        frame_error <= 1'b1;
        state_reg   <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (sd_rise) begin
              state_reg    <= WAIT_T;
              accepted_reg <= '0;
              ovf_reg      <= 1'b0;
            end
          end
          WAIT_T: begin
            if (sl_time) state_reg <= T_SHIFT;
          end
          T_SHIFT: begin
            if (time_last) begin
              state_reg     <= WAIT_CH;
              time_pend_reg <= 1'b1;
            end
          end
          WAIT_CH: begin
            if (sd_fall) begin
              frame_done   <= 1'b1;
              sample_count <= accepted_reg;
              overflow     <= ovf_reg;
              state_reg    <= IDLE;
            end else if (sl_ch) begin
              state_reg <= C_SHIFT;
            end
          end
          C_SHIFT: begin
            if (code_last) begin
              state_reg <= WAIT_CH;
              if (accepted_reg < CNT_BITS'(MAX_SAMPLES)) begin
                samp_pend_reg <= 1'b1;
                pend_idx_reg  <= accepted_reg[IDX_BITS-1:0];
                accepted_reg  <= accepted_reg + 1'b1;
              end else begin
                ovf_reg <= 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spectro_frame_receiver.sv
// Randomized frame-level bench: the driver serializes frames and records, from
// the frame contents alone, which output event is due on which clock edge.
module tb_spectro_frame_receiver;
  import spectro_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  serial_in;
  logic        sl_ch, sl_time, serial_readout, sending_data;
  logic [31:0] event_time;
  logic        time_valid;
  logic [2:0]  sample_ch1, sample_ch2;
  logic [8:0]  sample_idx;
  logic        sample_valid, frame_done;
  logic [9:0]  sample_count;
  logic        overflow, frame_error, busy;

  spectro_frame_receiver #(.MSB_FIRST(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .sl_ch          (sl_ch),
    .sl_time        (sl_time),
    .serial_readout (serial_readout),
    .sending_data   (sending_data),
    .event_time     (event_time),
    .time_valid     (time_valid),
    .sample_ch1     (sample_ch1),
    .sample_ch2     (sample_ch2),
    .sample_idx     (sample_idx),
    .sample_valid   (sample_valid),
    .frame_done     (frame_done),
    .sample_count   (sample_count),
    .overflow       (overflow),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Expected events keyed by the clock edge on which they must appear
  bit          exp_tv [int];
  logic [31:0] exp_tval [int];
  bit          exp_sv [int];
  logic [2:0]  exp_s1 [int];
  logic [2:0]  exp_s2 [int];
  logic [8:0]  exp_sidx [int];
  bit          exp_fd [int];
  logic [9:0]  exp_fcnt [int];
  bit          exp_fovf [int];
  bit          exp_fe [int];

  // Frame contents
  logic [2:0] s1 [0:599];
  logic [2:0] s2 [0:599];

  // Observation tallies for the literal pins
  int          n_tv_seen = 0, n_sv_seen = 0, n_fd_seen = 0, n_fe_seen = 0;
  logic [31:0] last_time;
  logic [2:0]  last_s1, last_s2;
  logic [8:0]  last_idx;
  logic [9:0]  last_cnt;
  logic        last_ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, expv, cyc);
  endtask

  // Per-edge comparison of every output pulse against the expected schedule
  initial begin
    bit e_tv, e_sv, e_fd, e_fe;
    forever begin
      @(posedge clk);
      #1;
      e_tv = exp_tv.exists(cyc);
      e_sv = exp_sv.exists(cyc);
      e_fd = exp_fd.exists(cyc);
      e_fe = exp_fe.exists(cyc);
      check("pulses{tv,sv,fd,fe}", {time_valid, sample_valid, frame_done, frame_error},
            {e_tv, e_sv, e_fd, e_fe});
      if (time_valid) begin
        n_tv_seen++; last_time = event_time;
        $display("edge %0d time  0x%08h", cyc, event_time);
        if (e_tv) check("event_time", event_time, exp_tval[cyc]);
      end
      if (sample_valid) begin
        n_sv_seen++; last_s1 = sample_ch1; last_s2 = sample_ch2; last_idx = sample_idx;
        $display("edge %0d sample idx=%0d ch1=%0d ch2=%0d", cyc, sample_idx, sample_ch1, sample_ch2);
        if (e_sv) check("sample{idx,ch1,ch2}", {sample_idx, sample_ch1, sample_ch2},
                        {exp_sidx[cyc], exp_s1[cyc], exp_s2[cyc]});
      end
      if (frame_done) begin
        n_fd_seen++; last_cnt = sample_count; last_ovf = overflow;
        $display("edge %0d done  count=%0d overflow=%0d", cyc, sample_count, overflow);
        if (e_fd) check("done{count,ovf}", {sample_count, overflow}, {exp_fcnt[cyc], exp_fovf[cyc]});
      end
      if (frame_error) begin
        n_fe_seen++;
        $display("edge %0d frame_error", cyc);
      end
    end
  end

  // Inputs set here are sampled on the next edge (number cyc+1)
  task automatic drive(input logic sd, input logic st, input logic sc, input logic rd,
                       input logic [1:0] lanes);
    sending_data = sd; sl_time = st; sl_ch = sc; serial_readout = rd; serial_in = lanes;
    @(posedge clk);
    #2;
  endtask

  task automatic gap_cycles(input int gm);
    int n;
    n = (gm < 0) ? int'($urandom_range(0, 3)) : gm;
    repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 2'($urandom));
  endtask

  // One frame: ab_s/ab_b select an abort (drop sending_data) before bit ab_b of sample ab_s
  task automatic send_frame(input logic [31:0] ts, input int n, input int gm,
                            input int ab_s, input int ab_b);
    drive(1'b0, 1'b0, 1'b0, 1'($urandom), 2'($urandom));
    drive(1'b0, 1'b0, 1'b0, 1'($urandom), 2'($urandom));
    drive(1'b1, 1'b0, 1'b0, 1'($urandom), 2'($urandom));
    check("busy_open", busy, 1);
    drive(1'b1, 1'b1, 1'b0, 1'($urandom), 2'($urandom));
    for (int k = 0; k < 32; k++) begin
      gap_cycles(gm);
      if (k == 31) begin exp_tv[cyc+2] = 1'b1; exp_tval[cyc+2] = ts; end
      drive(1'b1, 1'b0, 1'b0, 1'b1, {1'($urandom), ts[31-k]});
    end
    for (int i = 0; i < n; i++) begin
      gap_cycles(gm);
      drive(1'b1, 1'b0, 1'b1, 1'($urandom), 2'($urandom));
      for (int b = 0; b < 3; b++) begin
        if (i == ab_s && b == ab_b) begin
          exp_fe[cyc+1] = 1'b1;
          drive(1'b0, 1'b0, 1'b0, 1'($urandom), 2'($urandom));
          check("busy_after_error", busy, 0);
          return;
        end
        gap_cycles(gm);
        if (b == 2 && i < 512) begin
          exp_sv[cyc+2] = 1'b1; exp_s1[cyc+2] = s1[i]; exp_s2[cyc+2] = s2[i];
          exp_sidx[cyc+2] = 9'(i);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, {s2[i][2-b], s1[i][2-b]});
      end
    end
    gap_cycles(gm);
    exp_fd[cyc+1] = 1'b1;
    exp_fcnt[cyc+1] = 10'((n > 512) ? 512 : n);
    exp_fovf[cyc+1] = (n > 512);
    drive(1'b0, 1'b0, 1'b0, 1'($urandom), 2'($urandom));
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {event_time, time_valid, sample_ch1, sample_ch2, sample_idx, sample_valid,
                 frame_done, sample_count, overflow, frame_error, busy}, 64'd0);
  endtask

  task automatic pin_t1(input string tag, input int sv0, input int fd0);
    check({tag, "_time"}, last_time, 32'h8A5C_3E17);
    check({tag, "_fields"}, {last_time[TS_DAY_LSB +: TS_DAY_W], last_time[TS_HOUR_LSB +: TS_HOUR_W],
                             last_time[TS_MIN_LSB +: TS_MIN_W], last_time[TS_SEC_LSB +: TS_SEC_W],
                             last_time[TS_MS_LSB +: TS_MS_W]},
          {5'd17, 5'd9, 6'd28, 6'd15, 10'd535});
    check({tag, "_nsamples"}, n_sv_seen - sv0, 3);
    check({tag, "_last_sample"}, {last_idx, last_s1, last_s2}, {9'd2, 3'd3, 3'd3});
    check({tag, "_done"}, {n_fd_seen - fd0, last_cnt, last_ovf}, {32'd1, 10'd3, 1'b0});
  endtask

  initial begin
    int sv0, fd0, fe0, tv0;
    reset = 1'b0; sending_data = 1'b1; sl_ch = 1'b0; sl_time = 1'b0;
    serial_readout = 1'b0; serial_in = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset_state");

    // sending_data already high out of reset: a whole frame's worth of strobes is ignored
    reset = 1'b1;
    tv0 = n_tv_seen; fe0 = n_fe_seen;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 32; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 2'($urandom));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 2'($urandom));
    check("no_frame_busy", busy, 0);
    check("no_frame_events", {n_tv_seen - tv0, n_fe_seen - fe0}, 64'd0);

    // T1 / T2: known frame, contiguous then gapped readout
    s1[0] = 3'd5; s2[0] = 3'd2; s1[1] = 3'd0; s2[1] = 3'd7; s1[2] = 3'd3; s2[2] = 3'd3;
    sv0 = n_sv_seen; fd0 = n_fd_seen;
    send_frame(32'h8A5C_3E17, 3, 0, -1, 0);
    pin_t1("t1", sv0, fd0);
    sv0 = n_sv_seen; fd0 = n_fd_seen;
    send_frame(32'h8A5C_3E17, 3, 2, -1, 0);
    pin_t1("t2", sv0, fd0);

    // T3: sending_data drops after 2 of 3 bits of sample 1
    sv0 = n_sv_seen; fd0 = n_fd_seen; fe0 = n_fe_seen;
    send_frame(32'h1234_5678, 2, -1, 1, 2);
    check("t3_events", {n_sv_seen - sv0, n_fd_seen - fd0, n_fe_seen - fe0}, {32'd1, 32'd0, 32'd1});

    // T4: 530 samples offered
    for (int i = 0; i < 530; i++) begin s1[i] = 3'($urandom); s2[i] = 3'($urandom); end
    sv0 = n_sv_seen;
    send_frame($urandom, 530, -1, -1, 0);
    check("t4_nsamples", n_sv_seen - sv0, 512);
    check("t4_done", {last_idx, last_cnt, last_ovf}, {9'd511, 10'd512, 1'b1});

    // T5: reset mid timestamp, then a clean frame
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 2'($urandom));
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_all_zero("t5_reset_outputs");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin s1[i] = 3'($urandom); s2[i] = 3'($urandom); end
    send_frame($urandom, 5, -1, -1, 0);
    check("t5_done_count", last_cnt, 5);

    // T6: sl_ch during the timestamp aborts the frame
    fe0 = n_fe_seen; tv0 = n_tv_seen;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 2'($urandom));
    exp_fe[cyc+1] = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'($urandom));
    check("t6_busy", busy, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check("t6_events", {n_fe_seen - fe0, n_tv_seen - tv0}, {32'd1, 32'd0});

    // Zero-sample frame, then a few random frames
    send_frame($urandom, 0, -1, -1, 0);
    check("zero_frame_count", {last_cnt, last_ovf}, 11'd0);
    for (int f = 0; f < 4; f++) begin
      int n;
      n = int'($urandom_range(0, 8));
      for (int i = 0; i < n; i++) begin s1[i] = 3'($urandom); s2[i] = 3'($urandom); end
      send_frame($urandom, n, -1, -1, 0);
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
